nyq_out_fifo: RTL and testbench
===============================

Name: nyq_out_fifo

Overview:
- Buffers the decimated samples produced by the Nyquist filter stage, one sample per valid pulse.
- Hands them to the downstream consumer over a valid/ready handshake, so downstream stalls do not lose samples until the buffer is full.
- Uses the common parameter write bus for its own small configuration registers: threshold, enable, flag clear.
- Reports fill level, almost-full and a sticky overflow flag.

Parameters:
- ADDR_WIDTH, 9, width of the shared parameter address bus.
- MEM_WIDTH, 32, width of the shared parameter data bus.
- DATA_WIDTH, 24, sample width (matches filter output).
- DEPTH_LOG2, 4, log2 of FIFO depth; DEPTH = 2^DEPTH_LOG2 = 16.

Ports:
- Clk_CI  in  1  clock
- Rst_RI  in  1  reset
- WrEn_SI  in  1  parameter write enable, active high
- Addr_DI  in  ADDR_WIDTH  parameter address
- PAR_In_DI  in  MEM_WIDTH  parameter data
- In_DI  in  DATA_WIDTH  signed sample from filter stage
- InValid_SI  in  1  In_DI valid this cycle (push request)
- Out_DO  out  DATA_WIDTH  signed head sample
- OutValid_SO  out  1  Out_DO holds a valid sample
- OutReady_SI  in  1  consumer accepts Out_DO this cycle
- Level_DO  out  DEPTH_LOG2+1  number of stored samples
- AlmostFull_SO  out  1  Level_DO >= threshold
- Ovf_SO  out  1  sticky overflow flag
- Peak_DO  out  DATA_WIDTH  peak magnitude (optional feature)

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clk_CI is the clock, Rst_RI is the reset.
- Reset values:
  - pointers, Level_DO, Ovf_SO, OutValid_SO, Out_DO, Peak_DO: all 0.
  - thresh = DEPTH/2, en = 1.
  - Storage contents are not reset.
- Config registers, written only when WrEn_SI = 1; all other addresses are ignored:
  - Addr 0: thresh = PAR_In_DI[DEPTH_LOG2:0].
  - Addr 1: bit0 = 1 clears Ovf_SO. Self-clearing command; no stored state.
  - Addr 2: en = PAR_In_DI[0].
  - Addr 3: bit0 = 1 clears Peak_DO (optional feature only).
- Push = InValid_SI && en. Pop = OutValid_SO && OutReady_SI.
- Show-ahead:
  - Out_DO = storage[rd_ptr] when OutValid_SO = 1, else 0.
  - OutValid_SO = (Level_DO != 0).
  - A push into an empty FIFO at edge n makes OutValid_SO = 1 from edge n onward (latency 1 cycle).
- Level accounting:
  - Push only: Level_DO +1.
  - Pop only: Level_DO −1.
  - Push and pop in the same cycle: both succeed, level unchanged. This includes the full case.
  - Pointers wrap modulo DEPTH.
- Full: push while Level_DO = DEPTH and no pop in the same cycle → sample dropped, storage unchanged, Ovf_SO set at that edge.
- Ovf_SO clear vs. set in the same cycle: set wins.
- Empty: pop is impossible because OutValid_SO = 0. Push alone is accepted.
- en = 0:
  - At the edge following the write, pointers and Level_DO are flushed to 0.
  - Pushes are ignored and are not counted as overflow.
  - Ovf_SO and thresh are retained.
- AlmostFull_SO = (Level_DO >= thresh), evaluated combinationally on registered level. thresh = 0 forces it to 1.
- Reset asserted mid-operation: all state returns to reset values immediately. Data in flight is lost.

Optional Feature:
- Macro: NYQF_PEAK_EN.
- Defined:
  - Peak_DO tracks the maximum |In_DI| over accepted pushes. A dropped sample is not an accepted push and is not tracked.
  - Magnitude saturates: |−2^(DATA_WIDTH−1)| = 2^(DATA_WIDTH−1)−1.
  - Updated at the push edge; cleared by an Addr 3 write.
  - Clear vs. update in the same cycle: Peak_DO loads |In_DI|.
- Undefined: Peak_DO tied to 0, no peak logic, Addr 3 ignored.

Test Plan:
- Reset, then push 0x000123 with OutReady_SI = 0 → next cycle OutValid_SO = 1, Out_DO = 0x000123, Level_DO = 1.
- Push 17 samples 1..17 with OutReady_SI = 0:
  - Level_DO saturates at 16 and Ovf_SO = 1 after the 17th push.
  - Draining yields 1..16 in order; sample 17 is absent.
- At full, push 0xABCDEF with OutReady_SI = 1 in the same cycle → Level_DO stays 16 and the popped sample is the oldest; after draining, 0xABCDEF is the last sample output.
- Write Addr 0 = 3, push 3 samples → AlmostFull_SO rises on the 3rd push; one pop → AlmostFull_SO = 0.
- Ovf_SO clear vs. set:
  - With Ovf_SO = 1, write Addr 1 = 1 → Ovf_SO = 0 next cycle.
  - Repeat while pushing at full in the same cycle → Ovf_SO stays 1.
- With 5 samples stored, write Addr 2 = 0:
  - Level_DO = 0 and OutValid_SO = 0 next cycle.
  - Pushes are ignored with Ovf_SO unchanged.
  - Rst_RI pulsed mid-burst → all outputs 0 immediately.
- (NYQF_PEAK_EN) Push 0x000010, 0xFFFF00 (−256), 0x000050 → Peak_DO = 0x000100; push 0x800000 → Peak_DO = 0x7FFFFF.

Source files
------------

// File: rtl/nyq_out_fifo.sv
// nyq_out_fifo
// Output buffer for the decimated Nyquist-filter samples. Samples are pushed
// one per InValid_SI pulse and presented show-ahead to the downstream consumer
// over a valid/ready handshake. Small configuration registers (almost-full
// threshold, enable, overflow clear, peak clear) live on the shared parameter
// write bus.
//
// Ports:
//   Clk_CI, Rst_RI          clock, asynchronous active-high reset
//   WrEn_SI/Addr_DI/PAR_In_DI parameter write bus
//                           (0: thresh, 1: ovf clear, 2: enable, 3: peak clear)
//   In_DI, InValid_SI       signed sample input and push request
//   Out_DO, OutValid_SO     show-ahead head sample and its valid
//   OutReady_SI             consumer accepts the head sample
//   Level_DO                number of stored samples
//   AlmostFull_SO           Level_DO >= threshold
//   Ovf_SO                  sticky overflow flag
//   Peak_DO                 peak |In_DI| over accepted pushes
//
// Optional feature macro: NYQF_PEAK_EN (peak-magnitude tracker). When it is
// undefined Peak_DO is tied to 0 and address 3 is ignored.
module nyq_out_fifo #(
    parameter int ADDR_WIDTH = 9,
    parameter int MEM_WIDTH  = 32,
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                         Clk_CI,
    input  logic                         Rst_RI,
    input  logic                         WrEn_SI,
    input  logic [ADDR_WIDTH-1:0]        Addr_DI,
    input  logic [MEM_WIDTH-1:0]         PAR_In_DI,
    input  logic signed [DATA_WIDTH-1:0] In_DI,
    input  logic                         InValid_SI,
    output logic signed [DATA_WIDTH-1:0] Out_DO,
    output logic                         OutValid_SO,
    input  logic                         OutReady_SI,
    output logic [DEPTH_LOG2:0]          Level_DO,
    output logic                         AlmostFull_SO,
    output logic                         Ovf_SO,
    output logic [DATA_WIDTH-1:0]        Peak_DO
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LVL_ONE    = 1;
    localparam logic [DEPTH_LOG2:0]   THRESH_RST = {2'b01, {(DEPTH_LOG2-1){1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;

    logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [DEPTH_LOG2:0]   thresh_q, thresh_d;
    logic                  en_q, en_d;
    logic                  ovf_q, ovf_d;

    logic push, pop, full, push_ok;
    logic cfg_thresh, cfg_ovf_clr, cfg_en;

    // Upper parameter-data bits carry nothing for this block.
    logic unused_par;
    assign unused_par = ^PAR_In_DI[MEM_WIDTH-1:DEPTH_LOG2+1];

    assign cfg_thresh  = WrEn_SI && (Addr_DI == ADDR_WIDTH'(0));
    assign cfg_ovf_clr = WrEn_SI && (Addr_DI == ADDR_WIDTH'(1)) && PAR_In_DI[0];
    assign cfg_en      = WrEn_SI && (Addr_DI == ADDR_WIDTH'(2));

    assign push = InValid_SI && en_q;
    assign pop  = OutValid_SO && OutReady_SI;
    assign full = (level_q == LVL_FULL);
    // A simultaneous pop frees a slot, so a push at full still succeeds.
    assign push_ok = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        thresh_d = cfg_thresh ? PAR_In_DI[DEPTH_LOG2:0] : thresh_q;
        en_d     = cfg_en ? PAR_In_DI[0] : en_q;
        ovf_d    = ovf_q;

        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push_ok && !pop)      level_d = level_q + LVL_ONE;
        else if (pop && !push_ok) level_d = level_q - LVL_ONE;

        // Clear first so that a concurrent overflow wins.
        if (cfg_ovf_clr)          ovf_d = 1'b0;
        if (push && full && !pop) ovf_d = 1'b1;

        // Disabling flushes the queue at the write edge and keeps it empty.
        if (!en_d) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            thresh_q <= THRESH_RST;
            en_q     <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            thresh_q <= thresh_d;
            en_q     <= en_d;
            ovf_q    <= ovf_d;
        end
    end

    // Sample storage is deliberately not reset.
    always_ff @(posedge Clk_CI) begin
        if (push_ok) mem_q[wr_ptr_q] <= In_DI;
    end

    assign OutValid_SO   = (level_q != '0);
    assign Out_DO        = OutValid_SO ? mem_q[rd_ptr_q] : '0;
    assign Level_DO      = level_q;
    assign AlmostFull_SO = (level_q >= thresh_q);
    assign Ovf_SO        = ovf_q;

`ifdef NYQF_PEAK_EN
    localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0]        S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    // |x| with the most negative code saturated to the largest positive one.
    function automatic logic [DATA_WIDTH-1:0] abs_sat(input logic signed [DATA_WIDTH-1:0] x);
        if (x == S_MIN)  return S_MAX;
        else if (x < 0)  return $unsigned(-x);
        else             return $unsigned(x);
    endfunction

    logic [DATA_WIDTH-1:0] peak_q, peak_d;
    logic [DATA_WIDTH-1:0] mag;
    logic                  cfg_peak_clr;

    assign cfg_peak_clr = WrEn_SI && (Addr_DI == ADDR_WIDTH'(3)) && PAR_In_DI[0];
    assign mag          = abs_sat(In_DI);

    // A clear coinciding with an accepted push loads that push's magnitude.
    always_comb begin
        peak_d = peak_q;
        if (cfg_peak_clr) peak_d = '0;
        if (push_ok && (cfg_peak_clr || (mag > peak_q))) peak_d = mag;
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) peak_q <= '0;
        else        peak_q <= peak_d;
    end

    assign Peak_DO = peak_q;
`else
    assign Peak_DO = '0;
`endif

endmodule

// File: tb/tb_nyq_out_fifo.sv
// Directed testbench for nyq_out_fifo: show-ahead push/pop, full/overflow,
// push+pop at full, threshold, overflow clear priority, enable flush,
// asynchronous reset and (with NYQF_PEAK_EN) the peak tracker.
module tb_nyq_out_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wren = 1'b0;
    logic [8:0]  addr = '0;
    logic [31:0] par = '0;
    logic [23:0] in_d = '0;
    logic        in_v = 1'b0;
    logic [23:0] out_d;
    logic        out_v;
    logic        out_r = 1'b0;
    logic [4:0]  level;
    logic        afull;
    logic        ovf;
    logic [23:0] peak;

    int errors = 0;
    int checks = 0;

    nyq_out_fifo dut (
        .Clk_CI       (clk),
        .Rst_RI       (rst),
        .WrEn_SI      (wren),
        .Addr_DI      (addr),
        .PAR_In_DI    (par),
        .In_DI        (in_d),
        .InValid_SI   (in_v),
        .Out_DO       (out_d),
        .OutValid_SO  (out_v),
        .OutReady_SI  (out_r),
        .Level_DO     (level),
        .AlmostFull_SO(afull),
        .Ovf_SO       (ovf),
        .Peak_DO      (peak)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [23:0] d, input logic rdy);
        in_d = d; in_v = 1'b1; out_r = rdy;
        tick();
        in_v = 1'b0; out_r = 1'b0;
    endtask

    task automatic pop1();
        out_r = 1'b1;
        tick();
        out_r = 1'b0;
    endtask

    task automatic wr(input logic [8:0] a, input logic [31:0] d);
        wren = 1'b1; addr = a; par = d;
        tick();
        wren = 1'b0; addr = '0; par = '0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_level", level, 0);
        chk("rst_valid", out_v, 0);
        chk("rst_out", out_d, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_afull", afull, 0);
        chk("rst_peak", peak, 0);
        rst = 1'b0;
        tick();

        // Single push, show-ahead latency
        push(24'h000123, 1'b0);
        chk("one_valid", out_v, 1);
        chk("one_out", out_d, 24'h000123);
        chk("one_level", level, 1);
        pop1();
        chk("one_pop_level", level, 0);
        chk("one_pop_out", out_d, 0);

        // Fill to 16 then overflow with the 17th sample
        for (int i = 1; i <= 16; i++) push(24'(i), 1'b0);
        chk("full_level", level, 16);
        chk("full_afull", afull, 1);
        chk("full_ovf", ovf, 0);
        push(24'd17, 1'b0);
        chk("ovf_level", level, 16);
        chk("ovf_set", ovf, 1);

        // Push and pop together at full
        in_d = 24'hABCDEF; in_v = 1'b1; out_r = 1'b1;
        #1;
        chk("pp_head", out_d, 1);
        tick();
        in_v = 1'b0; out_r = 1'b0;
        chk("pp_level", level, 16);
        for (int i = 2; i <= 16; i++) begin
            chk("drain_data", out_d, 32'(i));
            pop1();
        end
        chk("drain_last", out_d, 24'hABCDEF);
        pop1();
        chk("drain_level", level, 0);
        chk("drain_valid", out_v, 0);

        // Overflow clear, then clear coinciding with an overflow
        wr(9'd1, 32'd1);
        chk("ovf_clr", ovf, 0);
        for (int i = 0; i < 16; i++) push(24'(100 + i), 1'b0);
        wren = 1'b1; addr = 9'd1; par = 32'd1;
        push(24'h000999, 1'b0);
        wren = 1'b0; addr = '0; par = '0;
        chk("ovf_set_wins", ovf, 1);
        chk("ovf_set_level", level, 16);

        // Reduce to 5 stored samples, then disable
        for (int i = 0; i < 11; i++) pop1();
        chk("five_level", level, 5);
        chk("five_head", out_d, 111);
        wr(9'd2, 32'd0);
        chk("dis_level", level, 0);
        chk("dis_valid", out_v, 0);
        chk("dis_out", out_d, 0);
        chk("dis_ovf_kept", ovf, 1);
        wr(9'd1, 32'd1);
        for (int i = 0; i < 20; i++) push(24'(200 + i), 1'b0);
        chk("dis_push_level", level, 0);
        chk("dis_push_ovf", ovf, 0);
        wr(9'd2, 32'd1);

        // Threshold 3
        wr(9'd0, 32'd3);
        push(24'h11, 1'b0);
        chk("th_af1", afull, 0);
        push(24'h22, 1'b0);
        chk("th_af2", afull, 0);
        push(24'h33, 1'b0);
        chk("th_af3", afull, 1);
        chk("th_head", out_d, 24'h11);
        pop1();
        chk("th_af_pop", afull, 0);
        chk("th_level", level, 2);
        pop1(); pop1();
        wr(9'd0, 32'd0);
        chk("th0_level", level, 0);
        chk("th0_afull", afull, 1);

        // Peak tracker
        wr(9'd3, 32'd1);
`ifdef NYQF_PEAK_EN
        chk("pk_clr", peak, 0);
        push(24'h000010, 1'b0);
        chk("pk_1", peak, 24'h000010);
        push(24'hFFFF00, 1'b0);
        chk("pk_2", peak, 24'h000100);
        push(24'h000050, 1'b0);
        chk("pk_3", peak, 24'h000100);
        push(24'h800000, 1'b0);
        chk("pk_sat", peak, 24'h7FFFFF);
`else
        push(24'h000010, 1'b0);
        push(24'hFFFF00, 1'b0);
        push(24'h000050, 1'b0);
        push(24'h800000, 1'b0);
        chk("pk_tied", peak, 0);
`endif
        chk("pre_rst_level", level, 4);

        // Reset asserted mid-burst, away from a clock edge
        in_d = 24'h555555; in_v = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mr_level", level, 0);
        chk("mr_valid", out_v, 0);
        chk("mr_out", out_d, 0);
        chk("mr_ovf", ovf, 0);
        chk("mr_afull", afull, 0);
        chk("mr_peak", peak, 0);
        in_v = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        push(24'h000042, 1'b0);
        chk("post_rst_out", out_d, 24'h000042);
        chk("post_rst_level", level, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
